// File: rtl/seg_write_arbiter.sv
// ============================================================================
// Module   : seg_write_arbiter
// Purpose  : Round-robin arbiter granting two requesters access to a
//            seven-segment decoder slave, with a per-write dwell period.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_write_arbiter #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [7:0]  data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [7:0]  data1,
  output logic        ack1,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [1:0]  S_IDLE       = 2'd0;
  localparam logic [1:0]  S_WRITE      = 2'd1;
  localparam logic [1:0]  S_HOLD       = 2'd2;
  localparam logic [15:0] C_DWELL_LOAD = 16'(DWELL - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [15:0] r_count;
  logic        r_last_grant;
  logic        r_grant_id;
  logic [7:0]  r_data;
  logic        w_any_req;
  logic        w_winner;

  assign w_any_req = req0 | req1;
  // On a tie the requester that did not win last time is served.
  assign w_winner  = (req0 && req1) ? ~r_last_grant : req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_HOLD;
      S_HOLD:  if (r_count == 16'd0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count      <= 16'd0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_data       <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_data       <= w_winner ? data1 : data0;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        S_WRITE: r_count <= C_DWELL_LOAD;
        S_HOLD:  if (r_count != 16'd0) r_count <= r_count - 16'd1;
        default: r_count <= 16'd0;
      endcase
    end
  end

  always_comb begin
    ack0         = 1'b0;
    ack1         = 1'b0;
    m_address    = 2'b00;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_writedata  = {24'h000000, r_data};
    busy         = (r_state == S_WRITE) || (r_state == S_HOLD);
    grant_id     = r_grant_id;
    if (r_state == S_WRITE) begin
      m_chipselect = 1'b1;
      m_write      = 1'b1;
      ack0         = ~r_grant_id;
      ack1         = r_grant_id;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_write_arbiter.sv
// ============================================================================
// Module   : tb_seg_write_arbiter
// Purpose  : Self-checking bench for seg_write_arbiter (DWELL=4 and DWELL=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, req0, req1;
  logic [7:0] data0, data1;

  logic        a_ack0, a_ack1, a_cs, a_wr, a_busy, a_gid;
  logic [1:0]  a_addr;
  logic [31:0] a_wd;
  logic        b_ack0, b_ack1, b_cs, b_wr, b_busy, b_gid;
  logic [1:0]  b_addr;
  logic [31:0] b_wd;

  seg_write_arbiter #(.DWELL(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .ack0(a_ack0),
    .req1(req1), .data1(data1), .ack1(a_ack1),
    .m_address(a_addr), .m_chipselect(a_cs), .m_write(a_wr),
    .m_writedata(a_wd), .busy(a_busy), .grant_id(a_gid)
  );

  seg_write_arbiter #(.DWELL(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .ack0(b_ack0),
    .req1(req1), .data1(data1), .ack1(b_ack1),
    .m_address(b_addr), .m_chipselect(b_cs), .m_write(b_wr),
    .m_writedata(b_wd), .busy(b_busy), .grant_id(b_gid)
  );

  logic [39:0] a_vec, b_vec;
  assign a_vec = {a_ack0, a_ack1, a_addr, a_cs, a_wr, a_wd, a_busy, a_gid};
  assign b_vec = {b_ack0, b_ack1, b_addr, b_cs, b_wr, b_wd, b_busy, b_gid};

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: cycles remaining in the current transaction (WRITE+HOLD).
  int         m_left[2];
  bit         m_last[2];
  bit         m_gid[2];
  logic [7:0] m_data[2];

  function automatic int dwell_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [39:0] expect_vec(int d);
    logic wr;
    wr = (m_left[d] == dwell_of(d) + 1);
    return {wr && !m_gid[d], wr && m_gid[d], 2'b00, wr, wr,
            24'h000000, m_data[d], m_left[d] > 0, m_gid[d]};
  endfunction

  task automatic tick();
    bit w;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_left[d] = 0; m_last[d] = 1'b1; m_gid[d] = 1'b0; m_data[d] = 8'h00;
      end else if (m_left[d] == 0) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? !m_last[d] : req1;
          m_last[d] = w;
          m_gid[d]  = w;
          m_data[d] = w ? data1 : data0;
          m_left[d] = dwell_of(d) + 1;
        end
      end else begin
        m_left[d]--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    req0 = 1'b0;
    req1 = 1'b0;
    n = 0;
    while ((a_busy || b_busy) && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (a_busy || b_busy) begin
      tests_failed++;
      $display("FAIL drain_timeout: busy a=%0b b=%0b, required 0", a_busy, b_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({a_vec, b_vec} !== 80'h0) begin
      tests_failed++;
      $display("FAIL reset_immediate: got a=%h b=%h, required 0", a_vec, b_vec);
    end
    tick();
    tick();
    tests_run++;
    if ({a_vec, b_vec} !== 80'h0) begin
      tests_failed++;
      $display("FAIL reset_held: got a=%h b=%h, required 0", a_vec, b_vec);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int busy_cnt;
    req0 = 1'b1; data0 = 8'h3A;
    tick();
    req0 = 1'b0;
    tests_run++;
    if ({a_ack0, a_ack1, a_cs, a_wr, a_addr, a_wd} !== {4'b1011, 2'b00, 32'h0000003A}) begin
      tests_failed++;
      $display("FAIL single_write: got ack0=%0b ack1=%0b cs=%0b wr=%0b addr=%0d wd=%h, required 1 0 1 1 0 0000003a",
               a_ack0, a_ack1, a_cs, a_wr, a_addr, a_wd);
    end
    busy_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!a_busy) break;
      busy_cnt++;
    end
    tests_run++;
    if (busy_cnt !== 5) begin
      tests_failed++;
      $display("FAIL single_busy_len: got %0d cycles, required 5", busy_cnt);
    end
    drain();
  endtask

  task automatic test_tie();
    int t[4];
    bit g[4];
    int n;
    bit coincide;
    n = 0; coincide = 1'b0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      tick();
      if (a_ack0 && a_ack1) coincide = 1'b1;
      if (a_wr) begin
        t[n] = cyc; g[n] = a_gid; n++;
      end
    end
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL tie_strobe_count: got %0d strobes, required 4", n);
    end else begin
      tests_run++;
      if (t[0] !== 1) begin
        tests_failed++;
        $display("FAIL tie_latency: first strobe at cycle %0d, required 1", t[0]);
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (g[i] !== bit'(i % 2)) begin
          tests_failed++;
          $display("FAIL tie_grant%0d: got %0d, required %0d", i, g[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        tests_run++;
        if (t[i] - t[i-1] !== 6) begin
          tests_failed++;
          $display("FAIL tie_spacing%0d: got %0d, required 6", i, t[i] - t[i-1]);
        end
      end
    end
    tests_run++;
    if (coincide !== 1'b0) begin
      tests_failed++;
      $display("FAIL tie_ack_overlap: got ack0&ack1=1, required 0");
    end
    drain();
  endtask

  task automatic test_hold_req();
    int k;
    k = -1;
    req0 = 1'b1; data0 = 8'h55;
    tick();
    req0 = 1'b0;
    tests_run++;
    if (a_ack0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_ack0: got %0b, required 1", a_ack0);
    end
    tick();
    req1 = 1'b1;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (a_wr) begin
        k = i;
        break;
      end
    end
    tests_run++;
    if (k !== 6 || a_ack1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_req_ack1: got strobe at +%0d ack1=%0b, required +6 ack1=1", k, a_ack1);
    end
    drain();
  endtask

  task automatic test_data_change();
    logic [31:0] bad;
    bad = 32'h00000012;
    req0 = 1'b1; data0 = 8'h12;
    tick();
    req0 = 1'b0; data0 = 8'hFF;
    tests_run++;
    if (a_wd !== 32'h00000012) begin
      tests_failed++;
      $display("FAIL data_write: got %h, required 00000012", a_wd);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_wd !== 32'h00000012) bad = a_wd;
      if (!a_busy) break;
    end
    tests_run++;
    if (bad !== 32'h00000012) begin
      tests_failed++;
      $display("FAIL data_stable: got %h, required 00000012", bad);
    end
    drain();
  endtask

  task automatic test_reset_mid_hold();
    req1 = 1'b1; data1 = 8'hC3;
    tick();
    req1 = 1'b0;
    tick();
    tick();
    tests_run++;
    if (a_busy !== 1'b1 || a_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL midhold_state: got busy=%0b wr=%0b, required 1 0", a_busy, a_wr);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({a_vec, b_vec} !== 80'h0) begin
      tests_failed++;
      $display("FAIL midhold_reset: got a=%h b=%h, required 0", a_vec, b_vec);
    end
    tick();
    tick();
    reset_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    tests_run++;
    if (a_ack0 !== 1'b1 || a_ack1 !== 1'b0 || a_gid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midhold_first_tie: got ack0=%0b ack1=%0b gid=%0b, required 1 0 0",
               a_ack0, a_ack1, a_gid);
    end
    drain();
  endtask

  task automatic test_dwell1();
    int t[3];
    int n, holds;
    n = 0; holds = 0;
    do_reset();
    req0 = 1'b1; data0 = 8'h7E;
    for (int cyc = 1; cyc <= 30 && n < 3; cyc++) begin
      tick();
      if (b_wr) begin
        t[n] = cyc; n++;
      end else if (b_busy && n > 0) begin
        holds++;
      end
    end
    tests_run++;
    if (n !== 3 || t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin
      tests_failed++;
      $display("FAIL dwell1_spacing: got n=%0d gaps %0d %0d, required 3 strobes gaps 3 3",
               n, t[1] - t[0], t[2] - t[1]);
    end
    tests_run++;
    if (holds !== 2) begin
      tests_failed++;
      $display("FAIL dwell1_hold: got %0d hold cycles over two writes, required 2", holds);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req0    = ($urandom_range(0, 2) != 0);
      req1    = ($urandom_range(0, 2) != 0);
      data0   = 8'($urandom);
      data1   = 8'($urandom);
      reset_n = ($urandom_range(0, 49) != 0);
      tick();
      tests_run++;
      if (a_vec !== expect_vec(0)) begin
        tests_failed++;
        $display("FAIL random_d4 cycle %0d: got %h, required %h", i, a_vec, expect_vec(0));
      end
      tests_run++;
      if (b_vec !== expect_vec(1)) begin
        tests_failed++;
        $display("FAIL random_d1 cycle %0d: got %h, required %h", i, b_vec, expect_vec(1));
      end
    end
    reset_n = 1'b1;
    drain();
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_last[d] = 1'b1; m_gid[d] = 1'b0; m_data[d] = 8'h00;
    end
    test_reset();
    test_single();
    test_tie();
    test_hold_req();
    test_data_change();
    test_reset_mid_hold();
    test_dwell1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
